// File: rtl/hash_arbiter_pkg.sv
// hash_arbiter_pkg
// Shared types and constants for the hash arbiter slice:
//   tuple_t        packed 5-tuple (src/dst IP, src/dst port, protocol)
//   l3_state_t     lookup3 working state {a, b, c}
//   HASH_LAT       hash core latency in cycles (fixed by the core)
//   HASH_ARB_ID_W  default requester ID width
//   rot32()        32-bit rotate-left helper
package hash_arbiter_pkg;

  localparam int HASH_LAT      = 8;
  localparam int HASH_ARB_ID_W = 3;

  // lookup3 initial value for a 13-byte key: 0xdeadbeef + 13.
  localparam logic [31:0] LOOKUP3_INIT = 32'hdeadbefc;

  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  proto;
  } tuple_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } l3_state_t;

  function automatic logic [31:0] rot32(input logic [31:0] x, input int unsigned k);
    return (x << k) | (x >> (32 - k));
  endfunction

endpackage

// File: rtl/hash_arbiter_rr.sv
// rr_arbiter
// Generic round-robin picker: first set bit of req searching from ptr upward,
// wrapping modulo NUM_REQ.
//   req           request vector
//   ptr           search start index (must be < NUM_REQ)
//   grant_onehot  one-hot grant, zero when no request
//   grant_idx     index of the granted requester
//   any           at least one request present
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  int idx;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    idx          = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      // Constant-index compare keeps the select width-exact.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == idx && req[i] && !any) begin
          any             = 1'b1;
          grant_onehot[i] = 1'b1;
          grant_idx       = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/hash_func.sv
// hash_func
// 8-stage lookup3-final tuple hash core.
//   clk            clock
//   stall          freezes every stage when high
//   tuple_in       5-tuple to hash
//   tuple_in_valid tuple_in carries a real request this cycle
//   initval        seed, consumed only when the tuple enters stage 0
//   hashed         hash result (lookup3 'c'), valid HASH_LAT cycles after issue
// The internal valid chain has no reset and only gates stage loads; results
// are qualified by the caller's own tag pipe.
module hash_func
  import hash_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        stall,
  input  tuple_t      tuple_in,
  input  logic        tuple_in_valid,
  input  logic [31:0] initval,
  output logic [31:0] hashed
);

  function automatic l3_state_t l3_load(input tuple_t t, input logic [31:0] seed);
    l3_state_t s;
    logic [31:0] init;
    init = LOOKUP3_INIT + seed;
    s.a  = init + t.src_ip + {24'h0, t.proto};
    s.b  = init + t.dst_ip;
    s.c  = init + {t.src_port, t.dst_port};
    return s;
  endfunction

  // One line of lookup3 final() per stage.
  function automatic l3_state_t l3_final_step(input int k, input l3_state_t s);
    l3_state_t r;
    r = s;
    case (k)
      1: r.c = (r.c ^ r.b) - rot32(r.b, 14);
      2: r.a = (r.a ^ r.c) - rot32(r.c, 11);
      3: r.b = (r.b ^ r.a) - rot32(r.a, 25);
      4: r.c = (r.c ^ r.b) - rot32(r.b, 16);
      5: r.a = (r.a ^ r.c) - rot32(r.c, 4);
      6: r.b = (r.b ^ r.a) - rot32(r.a, 14);
      7: r.c = (r.c ^ r.b) - rot32(r.b, 24);
      default: r = s;
    endcase
    return r;
  endfunction

  logic      vld_p [HASH_LAT-1];
  l3_state_t st_p  [HASH_LAT];

  // Stage 0: load with seed; stages 1..7: one final() step each
  always_ff @(posedge clk) begin
    if (!stall) begin
      vld_p[0] <= tuple_in_valid;
      if (tuple_in_valid) st_p[0] <= l3_load(tuple_in, initval);
      for (int k = 1; k < HASH_LAT - 1; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
      for (int k = 1; k < HASH_LAT; k++) begin
        if (vld_p[k-1]) st_p[k] <= l3_final_step(k, st_p[k-1]);
      end
    end
  end

  assign hashed = st_p[HASH_LAT-1].c;

endmodule

// File: rtl/hash_arbiter.sv
// hash_arbiter
// Shares one HASH_LAT-stage tuple hash core among NUM_REQ requesters with
// round-robin grant, carrying the requester ID alongside each tuple.
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      per-requester request valid
//   req_tuple      per-requester 5-tuple
//   req_ready      per-requester accept (one-hot or zero)
//   cfg_wr         load cfg_initval into the hash seed
//   cfg_initval    seed value
//   out_valid      result valid
//   out_hash       hash result
//   out_id         requester that issued the tuple
//   out_ready      consumer accepts result; low with out_valid stalls everything
// Optional (HASH_ARB_STATS_EN defined):
//   stats_clr      synchronously zero all counters
//   grant_cnt      per-requester saturating accepted-request count
//   stall_cnt      saturating stall-cycle count
module hash_arbiter
  import hash_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = HASH_ARB_ID_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef HASH_ARB_STATS_EN
  input  logic                     stats_clr,
  output logic [NUM_REQ-1:0][31:0] grant_cnt,
  output logic [31:0]              stall_cnt,
`endif
  input  logic [NUM_REQ-1:0]       req_valid,
  input  tuple_t [NUM_REQ-1:0]     req_tuple,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     cfg_wr,
  input  logic [31:0]              cfg_initval,
  output logic                     out_valid,
  output logic [31:0]              out_hash,
  output logic [ID_W-1:0]          out_id,
  input  logic                     out_ready
);

  logic               stall;
  logic               issue;
  logic [ID_W-1:0]    rr_ptr;
  logic [31:0]        seed;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  tuple_t             tuple_in;

  logic               tag_vld_p [HASH_LAT];
  logic [ID_W-1:0]    tag_id_p  [HASH_LAT];

  assign stall = out_valid & ~out_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req          (req_valid),
    .ptr          (rr_ptr),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign req_ready = rst_n ? (grant_onehot & {NUM_REQ{~stall}}) : '0;
  assign issue     = grant_any & ~stall;

  always_comb begin
    tuple_in = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_onehot[i]) tuple_in = req_tuple[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      seed   <= 32'h0;
    end else begin
      if (issue) begin
        if (grant_idx == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
        else                                 rr_ptr <= grant_idx + 1'b1;
      end
      // The core samples seed at its input stage, so a same-cycle issue
      // still sees the old value.
      if (cfg_wr) seed <= cfg_initval;
    end
  end

  hash_func u_hash (
    .clk            (clk),
    .stall          (stall),
    .tuple_in       (tuple_in),
    .tuple_in_valid (issue),
    .initval        (seed),
    .hashed         (out_hash)
  );

  // Tag pipe p0..p7: mirrors the core stage-for-stage, reset-clean valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HASH_LAT; i++) begin
        tag_vld_p[i] <= 1'b0;
        tag_id_p[i]  <= '0;
      end
    end else if (!stall) begin
      tag_vld_p[0] <= issue;
      tag_id_p[0]  <= grant_idx;
      for (int i = 1; i < HASH_LAT; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
        tag_id_p[i]  <= tag_id_p[i-1];
      end
    end
  end

  assign out_valid = tag_vld_p[HASH_LAT-1];
  assign out_id    = tag_id_p[HASH_LAT-1];

`ifdef HASH_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else if (stats_clr) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (issue && grant_onehot[i]) grant_cnt[i] <= sat_inc(grant_cnt[i]);
      end
      if (stall) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_hash_arbiter.sv
// tb_hash_arbiter
// Directed bench for hash_arbiter (NUM_REQ=4, ID_W=3). Set HASH_ARB_STATS_EN
// to also exercise the statistics counters.
module tb_hash_arbiter;
  import hash_arbiter_pkg::*;

  localparam int NREQ = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  tuple_t [NREQ-1:0] req_tuple;
  logic [NREQ-1:0]   req_ready;
  logic              cfg_wr;
  logic [31:0]       cfg_initval;
  logic              out_valid;
  logic [31:0]       out_hash;
  logic [2:0]        out_id;
  logic              out_ready;
`ifdef HASH_ARB_STATS_EN
  logic                   stats_clr;
  logic [NREQ-1:0][31:0]  grant_cnt;
  logic [31:0]            stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_h  [8];
  logic [2:0]  exp_id [8];
  tuple_t      tx, ta, tb2;
  int          bad;

  always #5 clk = ~clk;

  hash_arbiter #(.NUM_REQ(NREQ), .ID_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef HASH_ARB_STATS_EN
    .stats_clr   (stats_clr),
    .grant_cnt   (grant_cnt),
    .stall_cnt   (stall_cnt),
`endif
    .req_valid   (req_valid),
    .req_tuple   (req_tuple),
    .req_ready   (req_ready),
    .cfg_wr      (cfg_wr),
    .cfg_initval (cfg_initval),
    .out_valid   (out_valid),
    .out_hash    (out_hash),
    .out_id      (out_id),
    .out_ready   (out_ready)
  );

  function automatic logic [31:0] rl(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  // Golden lookup3: 13-byte key, words {src_ip+proto, dst_ip, ports}, final().
  function automatic logic [31:0] ref_hash(input tuple_t t, input logic [31:0] s);
    logic [31:0] a, b, c, iv;
    iv = 32'hdeadbeef + 32'd13 + s;
    a = iv + t.src_ip + {24'h0, t.proto};
    b = iv + t.dst_ip;
    c = iv + {t.src_port, t.dst_port};
    c ^= b; c -= rl(b, 14);
    a ^= c; a -= rl(c, 11);
    b ^= a; b -= rl(a, 25);
    c ^= b; c -= rl(b, 16);
    a ^= c; a -= rl(c, 4);
    b ^= a; b -= rl(a, 14);
    c ^= b; c -= rl(b, 24);
    return c;
  endfunction

  function automatic tuple_t mk(input int k, input int j);
    tuple_t t;
    t.src_ip   = 32'h0a00_0000 + 32'(k * 16 + j);
    t.dst_ip   = 32'hc0a8_0100 ^ 32'(k * 7919);
    t.src_port = 16'h1000 + 16'(k);
    t.dst_port = 16'h0050 + 16'(j);
    t.proto    = (j[0]) ? 8'd17 : 8'd6;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_tuple = '0; cfg_wr = 1'b0;
    cfg_initval = '0; out_ready = 1'b1;
`ifdef HASH_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_id",    32'(out_id),    32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    step();

    // Single request from requester 2, seed 0
    tx = mk(1, 2);
    req_tuple[2] = tx; req_valid = 4'b0100; #1;
    chk("t1_ready", 32'(req_ready), 32'b0100);
    step(); req_valid = '0;
    repeat (6) step();
    chk("t1_early", 32'(out_valid), 32'd0);
    step();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_id",    32'(out_id),    32'd2);
    chk("t1_hash",  out_hash,       ref_hash(tx, 32'h0));
    step();
    chk("t1_after", 32'(out_valid), 32'd0);

    // Requester 3 wraps the pointer back to 0
    req_tuple[3] = mk(2, 3); req_valid = 4'b1000; #1;
    chk("wrap_ready", 32'(req_ready), 32'b1000);
    step(); req_valid = '0;
    repeat (7) step();
    chk("wrap_id", 32'(out_id), 32'd3);
    step();

    // Round robin with all four requesting for 8 cycles
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < NREQ; j++) req_tuple[j] = mk(10 + i, j);
      req_valid = 4'b1111; #1;
      chk("rr_ready", 32'(req_ready), 32'(1 << (i % 4)));
      exp_id[i] = 3'(i % 4);
      exp_h[i]  = ref_hash(req_tuple[i % 4], 32'h0);
      step();
    end
    req_valid = '0; #1;
    for (int i = 0; i < 8; i++) begin
      chk("rr_valid", 32'(out_valid), 32'd1);
      chk("rr_id",    32'(out_id),    32'(exp_id[i]));
      chk("rr_hash",  out_hash,       exp_h[i]);
      step();
    end
    chk("rr_done", 32'(out_valid), 32'd0);

    // Backpressure: six from requester 0, five stall cycles at first result
    for (int i = 0; i < 6; i++) begin
      req_tuple[0] = mk(30 + i, 0); req_valid = 4'b0001; #1;
      chk("bp_ready", 32'(req_ready), 32'b0001);
      exp_h[i] = ref_hash(req_tuple[0], 32'h0);
      step();
    end
    req_valid = '0;
    step(); step();
    out_ready = 1'b0; req_tuple[1] = mk(50, 1); req_valid = 4'b0010; #1;
    for (int s = 0; s < 5; s++) begin
      chk("bp_stall_ready", 32'(req_ready), 32'd0);
      chk("bp_hold_valid",  32'(out_valid), 32'd1);
      chk("bp_hold_id",     32'(out_id),    32'd0);
      chk("bp_hold_hash",   out_hash,       exp_h[0]);
      step();
    end
    out_ready = 1'b1; req_valid = '0; #1;
    for (int i = 0; i < 6; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_hash",  out_hash,       exp_h[i]);
      step();
    end
    chk("bp_done", 32'(out_valid), 32'd0);

    // Seed write in the same cycle as A; B uses the new seed
    ta = mk(60, 2); tb2 = mk(61, 3);
    cfg_wr = 1'b1; cfg_initval = 32'h1234_5678;
    req_tuple[2] = ta; req_valid = 4'b0100; #1;
    chk("seed_a_ready", 32'(req_ready), 32'b0100);
    step(); cfg_wr = 1'b0;
    req_tuple[3] = tb2; req_valid = 4'b1000; #1;
    chk("seed_b_ready", 32'(req_ready), 32'b1000);
    step(); req_valid = '0;
    repeat (6) step();
    chk("seed_a_id",   32'(out_id), 32'd2);
    chk("seed_a_hash", out_hash,    ref_hash(ta, 32'h0));
    step();
    chk("seed_b_id",   32'(out_id), 32'd3);
    chk("seed_b_hash", out_hash,    ref_hash(tb2, 32'h1234_5678));
    step();

    // Asynchronous reset with five results in flight
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < NREQ; j++) req_tuple[j] = mk(70 + i, j);
      req_valid = 4'b1111;
      step();
    end
    req_valid = '0;
    repeat (3) step();
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_drop", 32'(out_valid), 32'd0);
    chk("ar_id_zero",    32'(out_id),    32'd0);
    req_valid = 4'b1111; #1;
    chk("ar_ready_zero", 32'(req_ready), 32'd0);
    rst_n = 1'b1; #1;
    chk("ar_ptr_reset", 32'(req_ready), 32'b0001);
    req_valid = '0;
    bad = 0;
    repeat (20) begin
      step();
      if (out_valid !== 1'b0) bad++;
    end
    chk("ar_quiet", 32'(bad), 32'd0);
    tx = mk(90, 0);
    req_tuple[0] = tx; req_valid = 4'b0001;
    step(); req_valid = '0;
    repeat (7) step();
    chk("ar_seed_id",   32'(out_id), 32'd0);
    chk("ar_seed_hash", out_hash,    ref_hash(tx, 32'h0));
    step();

`ifdef HASH_ARB_STATS_EN
    stats_clr = 1'b1; step(); stats_clr = 1'b0;
    chk("st_clr0_g0",  grant_cnt[0], 32'd0);
    chk("st_clr0_stl", stall_cnt,    32'd0);
    for (int i = 0; i < 10; i++) begin
      req_tuple[1] = mk(100 + i, 1); req_valid = 4'b0010;
      step();
    end
    req_valid = '0;
    chk("st_stall_vld", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (12) step();
    chk("st_g1",  grant_cnt[1], 32'd10);
    chk("st_g0",  grant_cnt[0], 32'd0);
    chk("st_stl", stall_cnt,    32'd3);
    stats_clr = 1'b1; req_valid = 4'b0010;
    step();
    stats_clr = 1'b0; req_valid = '0;
    chk("st_clr_g1",  grant_cnt[1], 32'd0);
    chk("st_clr_stl", stall_cnt,    32'd0);
    repeat (10) step();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
